// File: rtl/boxcar_decimator_pkg.sv
// Shared filter package: Q-format defaults plus the sign-extend and arithmetic
// shift helpers used by this and later decimating stages.
package boxcar_decimator_pkg;

   localparam int Q_W      = 16;
   localparam int Q_FRAC   = 8;
   // Helpers work on a fixed wide word; callers size-cast in and out.
   localparam int HELPER_W = 32;

   // Sign-extend the low w bits of v to the full helper width.
   function automatic logic signed [HELPER_W-1:0] sext(input logic [HELPER_W-1:0] v,
                                                       input int unsigned w);
      logic [HELPER_W-1:0] hi;
      logic                sgn;
      hi  = {HELPER_W{1'b1}} << w;
      sgn = |(v & (HELPER_W'(1) << (w - 1)));
      return sgn ? (v | hi) : (v & ~hi);
   endfunction

   function automatic logic signed [HELPER_W-1:0] asr(input logic signed [HELPER_W-1:0] v,
                                                      input int unsigned sh);
      return v >>> sh;
   endfunction

endpackage

// File: rtl/boxcar_decimator_stream_out_reg.sv
// Single-entry valid/ready output register; a load wins over a drain so
// back-to-back groups keep y_valid high.
module stream_out_reg
   import boxcar_decimator_pkg::*;
#(
   parameter int W = Q_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         y_ready,
   output logic [W-1:0] y_data,
   output logic         y_valid,
   output logic         free
);

   assign free = !y_valid || y_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         y_data  <= '0;
         y_valid <= 1'b0;
      end else if (load) begin
         y_data  <= load_data;
         y_valid <= 1'b1;
      end else if (y_valid && y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/boxcar_decimator.sv
// Block-mean decimator: sums 2^LOG2_N accepted samples and emits their floor
// average through a registered valid/ready output.
module boxcar_decimator
   import boxcar_decimator_pkg::*;
#(
   parameter int W      = Q_W,
   parameter int W_FRAC = Q_FRAC,
   parameter int LOG2_N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] x_data,
   input  logic         x_valid,
   output logic         x_ready,
   output logic [W-1:0] y_data,
   output logic         y_valid,
   input  logic         y_ready
);

   localparam int                ACC_W = W + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST  = LOG2_N'((1 << LOG2_N) - 1);

   if (LOG2_N < 1 || LOG2_N > 6 || W_FRAC >= W || ACC_W > HELPER_W) begin : g_bad_param
      $error("boxcar_decimator: illegal parameter combination");
   end

   logic [LOG2_N-1:0]       count;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] sum;
   logic [W-1:0]            avg;
   logic                    last;
   logic                    out_free;
   logic                    accept;
   logic                    complete;

   assign x_ext = ACC_W'(sext(HELPER_W'(x_data), W));
   assign sum   = acc + x_ext;
   assign avg   = W'(asr(HELPER_W'(sum), LOG2_N));

   // Only the group-completing sample needs room in the output register.
   assign last     = (count == LAST);
   assign x_ready  = !last || out_free;
   assign accept   = x_valid && x_ready;
   assign complete = accept && last;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         count <= '0;
      end else if (accept) begin
         if (last) begin
            acc   <= '0;
            count <= '0;
         end else begin
            acc   <= sum;
            count <= count + LOG2_N'(1);
         end
      end
   end

   stream_out_reg #(.W(W)) u_out (
      .clk       (clk),
      .reset     (reset),
      .load      (complete),
      .load_data (avg),
      .y_ready   (y_ready),
      .y_data    (y_data),
      .y_valid   (y_valid),
      .free      (out_free)
   );

endmodule
